control_fsm: RTL

//  Multi-cycle sequencer for the 16-bit datapath. Drives every datapath enable, mux

---
 rtl/control_fsm.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_fsm.sv
// Multi-cycle sequencer for the 16-bit datapath: decodes opcode/flags into datapath
// enables and ALU ops, and runs the req/ready memory handshake for fetch, load and store.
module control_fsm #(
   parameter int TIMEOUT_W = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       neg,
   input  logic       mem_ready,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       s_addr,
   output logic       en_inst,
   output logic       en_a,
   output logic       en_b,
   output logic       en_f,
   output logic       en_mdr,
   output logic       en_pc,
   output logic [3:0] alu_op,
   output logic       s_regfile_din,
   output logic       we_regfile,
   output logic       s_regfile_rw,
   output logic       halted,
   output logic       illegal,
   output logic       bus_err
);

   typedef enum logic [3:0] {
      S_INIT, S_FETCH, S_DECODE, S_EXEC, S_WB, S_ADDR_A, S_MRD, S_LWB,
      S_ADDR_B, S_MWR, S_BRTEST, S_BRTAKE, S_JAL1, S_JAL2, S_JR, S_HALT
   } state_t;

   localparam logic [3:0] ALU_PASSA  = 4'h5;
   localparam logic [3:0] ALU_PASSB  = 4'h6;
   localparam logic [3:0] ALU_PASSPC = 4'h7;
   localparam logic [3:0] ALU_INCPC  = 4'h8;
   localparam logic [3:0] ALU_IMM8   = 4'h9;
   localparam logic [3:0] ALU_BROFF  = 4'hA;
   localparam logic [3:0] ALU_JOFF   = 4'hB;
   localparam logic [3:0] ALU_ZERO   = 4'hF;

   localparam bit                   TIMEOUT_EN  = (TIMEOUT != 0);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(TIMEOUT);

   state_t               state_q, state_d;
   logic [TIMEOUT_W-1:0] wait_q, wait_d;
   logic                 illegal_q, illegal_d;
   logic                 bus_err_q, bus_err_d;
   logic                 mem_wait;
   logic                 timeout_hit;

   assign timeout_hit = TIMEOUT_EN && (wait_q == TIMEOUT_CNT) && !mem_ready;

   // Outputs are Mealy on mem_ready (enables fire in the completing cycle) and are
   // forced low while rst_n is held, ahead of the synchronous state reset.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d       = state_q;
      illegal_d     = illegal_q;
      bus_err_d     = bus_err_q;
      mem_wait      = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      s_addr        = 1'b0;
      en_inst       = 1'b0;
      en_a          = 1'b0;
      en_b          = 1'b0;
      en_f          = 1'b0;
      en_mdr        = 1'b0;
      en_pc         = 1'b0;
      alu_op        = 4'h0;
      s_regfile_din = 1'b0;
      we_regfile    = 1'b0;
      s_regfile_rw  = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            S_INIT: begin
               alu_op  = ALU_ZERO;
               en_pc   = 1'b1;
               state_d = S_FETCH;
            end
            S_FETCH: begin
               mem_rd = 1'b1;
               if (mem_ready) begin
                  en_inst = 1'b1;
                  en_pc   = 1'b1;
                  alu_op  = ALU_INCPC;
                  state_d = S_DECODE;
               end else if (timeout_hit) begin
                  state_d   = S_HALT;
                  bus_err_d = 1'b1;
               end else begin
                  mem_wait = 1'b1;
               end
            end
            S_DECODE: begin
               en_a = 1'b1;
               en_b = 1'b1;
               unique case (opcode)
                  4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8: state_d = S_EXEC;
                  4'h9:       state_d = S_ADDR_A;
                  4'hA:       state_d = S_ADDR_B;
                  4'hB, 4'hC: state_d = S_BRTEST;
                  4'hD:       state_d = S_JAL1;
                  4'hE:       state_d = S_JR;
                  4'hF:       state_d = S_HALT;
                  default: begin
                     state_d   = S_HALT;
                     illegal_d = 1'b1;
                  end
               endcase
            end
            S_EXEC: begin
               alu_op  = (opcode == 4'h8) ? ALU_IMM8 : opcode;
               en_f    = 1'b1;
               state_d = S_WB;
            end
            S_WB: begin
               we_regfile = 1'b1;
               state_d    = S_FETCH;
            end
            S_ADDR_A: begin
               alu_op  = ALU_PASSA;
               en_f    = 1'b1;
               state_d = S_MRD;
            end
            S_MRD: begin
               mem_rd = 1'b1;
               s_addr = 1'b1;
               if (mem_ready) begin
                  en_mdr  = 1'b1;
                  state_d = S_LWB;
               end else if (timeout_hit) begin
                  state_d   = S_HALT;
                  bus_err_d = 1'b1;
               end else begin
                  mem_wait = 1'b1;
               end
            end
            S_LWB: begin
               we_regfile    = 1'b1;
               s_regfile_din = 1'b1;
               state_d       = S_FETCH;
            end
            S_ADDR_B: begin
               alu_op  = ALU_PASSB;
               en_f    = 1'b1;
               state_d = S_MWR;
            end
            S_MWR: begin
               mem_wr = 1'b1;
               s_addr = 1'b1;
               if (mem_ready) begin
                  state_d = S_FETCH;
               end else if (timeout_hit) begin
                  state_d   = S_HALT;
                  bus_err_d = 1'b1;
               end else begin
                  mem_wait = 1'b1;
               end
            end
            S_BRTEST: begin
               alu_op = ALU_PASSA;
               if ((opcode == 4'hB && zero) || (opcode == 4'hC && neg)) state_d = S_BRTAKE;
               else                                                      state_d = S_FETCH;
            end
            S_BRTAKE: begin
               alu_op  = ALU_BROFF;
               en_pc   = 1'b1;
               state_d = S_FETCH;
            end
            S_JAL1: begin
               alu_op  = ALU_PASSPC;
               en_f    = 1'b1;
               state_d = S_JAL2;
            end
            S_JAL2: begin
               we_regfile   = 1'b1;
               s_regfile_rw = 1'b1;
               alu_op       = ALU_JOFF;
               en_pc        = 1'b1;
               state_d      = S_FETCH;
            end
            S_JR: begin
               alu_op  = ALU_PASSA;
               en_pc   = 1'b1;
               state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_INIT;
         endcase
      end
   end

   // The wait counter restarts whenever a memory state is entered or left.
   assign wait_d = mem_wait ? wait_q + TIMEOUT_W'(1) : '0;

   assign halted  = rst_n && (state_q == S_HALT);
   assign illegal = rst_n && illegal_q;
   assign bus_err = rst_n && bus_err_q;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q   <= S_INIT;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

endmodule
